// File: rtl/mem_store_chk_pkg.sv
// mem_store_checker shared types: store size, error cause, FSM state.
// size_mask() gives the data bits that take part in a compare.
package mem_store_chk_pkg;

  // Widest data bus size_mask() can describe.
  localparam int MAX_DATA_W = 64;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_HALF = 2'b10,
    SZ_BYTE = 2'b11
  } store_size_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ADDR    = 2'd1,
    ERR_DATA    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } chk_state_e;

  function automatic logic [MAX_DATA_W-1:0] size_mask(
    input store_size_e s
  );
    logic [MAX_DATA_W-1:0] m;
    m = '0;
    case (s)
      SZ_WORD: m = '1;
      SZ_HALF: m[15:0] = 16'hFFFF;
      SZ_BYTE: m[7:0] = 8'hFF;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_expect_fifo.sv
// store_expect_fifo: expected-store list, filled in LOAD, read in order in RUN.
// Ports: clk, rst_n; i_wr_* write side; i_rd_en pops; o_rd_* head entry;
// o_full, o_last (head is final loaded entry), o_count, o_rd_ptr.
module store_expect_fifo
  import mem_store_chk_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_EXP  = 8,
  parameter int CW     = $clog2(N_EXP + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [1:0]        i_wr_size,
  input  logic              i_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [1:0]        o_rd_size,
  output logic              o_full,
  output logic              o_last,
  output logic [CW-1:0]     o_count,
  output logic [CW-1:0]     o_rd_ptr
);

  localparam int PW = (N_EXP > 1) ? $clog2(N_EXP) : 1;

  logic [ADDR_W-1:0] r_addr [N_EXP];
  logic [DATA_W-1:0] r_data [N_EXP];
  logic [1:0]        r_size [N_EXP];

  // Nothing is popped while loading, so the write pointer is the count.
  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_rd_idx;
  logic          w_wr;
  logic          w_rd;

  assign w_wr_idx = r_wr_ptr[PW-1:0];
  assign w_rd_idx = r_rd_ptr[PW-1:0];
  assign o_full   = (r_wr_ptr == CW'(N_EXP));
  assign w_wr     = i_wr_en && !o_full;
  assign w_rd     = i_rd_en && (r_rd_ptr < r_wr_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < N_EXP; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_size[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_addr[w_wr_idx] <= i_wr_addr;
        r_data[w_wr_idx] <= i_wr_data;
        r_size[w_wr_idx] <= i_wr_size;
        r_wr_ptr         <= r_wr_ptr + CW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + CW'(1);
      end
    end
  end

  assign o_rd_addr = r_addr[w_rd_idx];
  assign o_rd_data = r_data[w_rd_idx];
  assign o_rd_size = r_size[w_rd_idx];
  assign o_last    = (CW'(r_rd_ptr + CW'(1)) == r_wr_ptr);
  assign o_count   = r_wr_ptr;
  assign o_rd_ptr  = r_rd_ptr;

endmodule

// File: rtl/mem_store_checker.sv
// mem_store_checker: in-order, size-aware, timeout-guarded data-store checker.
// Ports: clk, reset (async low); exp_* load list; start; memwrite/dataadr/
// writedata observed; done/pass/fail/err_code/match_count/fail_* results.
// Define MEM_STORE_CHECKER_CAPTURE_EN to latch the offending store in fail_*.
module mem_store_checker
  import mem_store_chk_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int N_EXP   = 8,
  parameter int TIMEOUT = 1000,
  parameter int STRICT  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         exp_valid,
  input  logic [ADDR_W-1:0]            exp_addr,
  input  logic [DATA_W-1:0]            exp_data,
  input  logic [1:0]                   exp_size,
  output logic                         exp_ready,
  input  logic                         start,
  input  logic [1:0]                   memwrite,
  input  logic [ADDR_W-1:0]            dataadr,
  input  logic [DATA_W-1:0]            writedata,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic [1:0]                   err_code,
  output logic [$clog2(N_EXP+1)-1:0]   match_count,
  output logic [ADDR_W-1:0]            fail_addr,
  output logic [DATA_W-1:0]            fail_data,
  output logic [1:0]                   fail_size
);

  localparam int CW = $clog2(N_EXP + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  chk_state_e r_state;
  chk_state_e w_nxt_state;
  err_code_e  r_err;
  err_code_e  w_nxt_err;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_nxt_timer;
  logic r_pass;
  logic r_fail;
  logic r_done;

  logic              w_wr_en;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_e_addr;
  logic [DATA_W-1:0] w_e_data;
  logic [1:0]        w_e_size;
  logic              w_full;
  logic              w_last;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_rd_ptr;

  logic              w_store;
  logic              w_addr_eq;
  logic              w_size_eq;
  logic              w_data_eq;
  logic              w_match;
  logic [DATA_W-1:0] w_mask;

  assign exp_ready = (r_state == S_LOAD) && !w_full;
  assign w_wr_en   = exp_valid && exp_ready;

  store_expect_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .N_EXP  (N_EXP),
    .CW     (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (exp_addr),
    .i_wr_data (exp_data),
    .i_wr_size (exp_size),
    .i_rd_en   (w_rd_en),
    .o_rd_addr (w_e_addr),
    .o_rd_data (w_e_data),
    .o_rd_size (w_e_size),
    .o_full    (w_full),
    .o_last    (w_last),
    .o_count   (w_count),
    .o_rd_ptr  (w_rd_ptr)
  );

  // Only bits covered by the expected size take part in the data compare.
  assign w_mask    = DATA_W'(size_mask(store_size_e'(w_e_size)));
  assign w_store   = (memwrite != SZ_NONE);
  assign w_addr_eq = (dataadr == w_e_addr);
  assign w_size_eq = (memwrite == w_e_size);
  assign w_data_eq = (((writedata ^ w_e_data) & w_mask) == '0);
  assign w_match   = w_store && w_addr_eq && w_size_eq && w_data_eq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_LOAD;
      r_err   <= ERR_NONE;
      r_timer <= '0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_err   <= w_nxt_err;
      r_timer <= w_nxt_timer;
      r_pass  <= (w_nxt_state == S_PASS);
      r_fail  <= (w_nxt_state == S_FAIL);
      r_done  <= (w_nxt_state == S_PASS) || (w_nxt_state == S_FAIL);
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_err   = r_err;
    w_nxt_timer = r_timer;
    w_rd_en     = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        w_nxt_timer = '0;
        if (start) begin
          // An entry accepted together with start still counts.
          if ((w_count == '0) && !w_wr_en) begin
            w_nxt_state = S_PASS;
          end else begin
            w_nxt_state = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_match) begin
          w_rd_en     = 1'b1;
          w_nxt_timer = '0;
          if (w_last) begin
            w_nxt_state = S_PASS;
          end
        end else if (w_store && !w_addr_eq) begin
          w_nxt_state = S_FAIL;
          w_nxt_err   = ERR_ADDR;
        end else if (w_store && (STRICT != 0)) begin
          w_nxt_state = S_FAIL;
          w_nxt_err   = ERR_DATA;
        end else if ((TIMEOUT != 0) &&
                     (r_timer == TW'(TIMEOUT - 1))) begin
          w_nxt_state = S_FAIL;
          w_nxt_err   = ERR_TIMEOUT;
        end else if (TIMEOUT != 0) begin
          w_nxt_timer = r_timer + TW'(1);
        end
      end
      S_PASS: ;
      S_FAIL: ;
      default: ;
    endcase
  end

  assign pass        = r_pass;
  assign fail        = r_fail;
  assign done        = r_done;
  assign err_code    = r_err;
  assign match_count = w_rd_ptr;

`ifdef MEM_STORE_CHECKER_CAPTURE_EN
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data;
  logic [1:0]        r_fail_size;
  logic              w_cap;
  logic              w_cap_exp;

  assign w_cap     = (r_state == S_RUN) && (w_nxt_state == S_FAIL);
  // A timeout has no offending store, so record what was awaited.
  assign w_cap_exp = (w_nxt_err == ERR_TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_fail_size <= '0;
    end else if (w_cap) begin
      r_fail_addr <= w_cap_exp ? w_e_addr : dataadr;
      r_fail_data <= w_cap_exp ? w_e_data : writedata;
      r_fail_size <= w_cap_exp ? w_e_size : memwrite;
    end
  end

  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;
  assign fail_size = r_fail_size;
`else
  assign fail_addr = '0;
  assign fail_data = '0;
  assign fail_size = '0;
`endif

endmodule
